sar_search_4bits: RTL and testbench

//  Successive-approximation search controller; consumer side of the magnitude-comparator interface.

---
 rtl/sar_search_4bits.sv | 125 ++++++++++++
 tb/tb_sar_search_4bits.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_4bits.sv
// Successive-approximation search controller.
// Drives a trial value onto comparator input b and resolves the unknown on
// input a MSB-first, using the equal / a_greater / b_greater flags. The
// search ends on the first equal or after the LSB trial, whichever comes first.
module sar_search_4bits #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_equal,
   input  logic             cmp_a_greater,
   input  logic             cmp_b_greater,
   output logic [WIDTH-1:0] guess,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             flag_err
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] GUESS_INIT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [IW-1:0]    IDX_INIT   = IW'(WIDTH-1);

   typedef enum logic {S_IDLE, S_TRIAL} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] guess_q, guess_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] trial_upd;
   logic             flags_legal;

   // Exactly one comparator flag high: odd parity rules out 0 and 2 high,
   // the AND term rules out all 3 high.
   always_comb begin
      flags_legal = (cmp_equal ^ cmp_a_greater ^ cmp_b_greater) &
                    ~(cmp_equal & cmp_a_greater & cmp_b_greater);
   end

   // Current trial bit resolved: cleared when the trial was too large,
   // otherwise kept (covers a_greater and the zero-flag case).
   always_comb begin
      trial_upd = guess_q;
      if (cmp_b_greater)
         trial_upd[idx_q] = 1'b0;
   end

   // Next-state logic for the search FSM and all registered outputs.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      guess_d  = guess_q;
      result_d = result_q;
      done_d   = 1'b0;
      busy_d   = busy_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               guess_d = GUESS_INIT;
               idx_d   = IDX_INIT;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = S_TRIAL;
            end
         end
         S_TRIAL: begin
            if (!flags_legal)
               err_d = 1'b1;
            if (cmp_equal) begin
               // Exact hit: finish early with the value on the bus.
               result_d = guess_q;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end else if (idx_q == '0) begin
               guess_d  = trial_upd;
               result_d = trial_upd;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end else begin
               // Resolve this bit and tentatively set the next lower one.
               guess_d                     = trial_upd;
               guess_d[idx_q - IW'(1)]     = 1'b1;
               idx_d                       = idx_q - IW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset abandons any search in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= IDX_INIT;
         guess_q  <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         guess_q  <= guess_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign guess    = guess_q;
   assign result   = result_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign flag_err = err_q;

endmodule

// File: tb/tb_sar_search_4bits.sv
// Bench for sar_search_4bits: behavioural comparator on (target, guess) with
// a flag-override hook; expected search outcomes are queued at start and
// checked by a monitor whenever done pulses.
module tb_sar_search_4bits;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       cmp_equal, cmp_a_greater, cmp_b_greater;
   logic [3:0] guess, result;
   logic       done, busy, flag_err;

   logic [3:0] tgt = 4'd0;
   logic       ovr_en = 1'b0;
   logic [2:0] ovr = 3'b000;   // {equal, a_greater, b_greater}

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      logic [3:0] res;
      logic       err;
      int         start_cyc;
      int         lat;
   } exp_t;

   exp_t sb[$];

   sar_search_4bits #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cmp_equal(cmp_equal), .cmp_a_greater(cmp_a_greater), .cmp_b_greater(cmp_b_greater),
      .guess(guess), .result(result), .done(done), .busy(busy), .flag_err(flag_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural comparator: a = target, b = guess.
   always_comb begin
      if (ovr_en) begin
         {cmp_equal, cmp_a_greater, cmp_b_greater} = ovr;
      end else begin
         cmp_equal     = (tgt == guess);
         cmp_a_greater = (tgt >  guess);
         cmp_b_greater = (tgt <  guess);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", int'(result), int'(e.res));
            chk("flag_err_at_done", int'(flag_err), int'(e.err));
            chk("latency", cyc - e.start_cyc, e.lat);
            chk("busy_at_done", int'(busy), 0);
         end
      end
   end

   // Drive one start pulse; returns at the negedge after the start edge.
   task automatic start_search(input logic [3:0] t, input logic [3:0] res,
                               input logic err, input int lat, input bit push);
      exp_t e;
      @(negedge clk);
      tgt   = t;
      start = 1'b1;
      if (push) begin
         e.res = res; e.err = err; e.start_cyc = cyc + 1; e.lat = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_guesses(input string name, input logic [15:0] gseq);
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         chk(name, int'(guess), int'(gseq[15-4*i -: 4]));
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_timeout_pending", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", int'({guess, result, done, busy, flag_err}), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_no_start", int'({guess, result, done, busy, flag_err}), 0);

      // target 11: 8,12,10,11, equal on 4th trial
      start_search(4'd11, 4'd11, 1'b0, 4, 1'b1);
      chk("busy_after_start", int'(busy), 1);
      check_guesses("guess_seq_11", 16'h8CAB);
      wait_drain();
      repeat (3) @(negedge clk);
      chk("guess_hold_idle", int'(guess), 11);
      chk("result_hold_idle", int'(result), 11);

      // target 0: 8,4,2,1 all b_greater
      start_search(4'd0, 4'd0, 1'b0, 4, 1'b1);
      check_guesses("guess_seq_0", 16'h8421);
      wait_drain();

      // target 8: equal on first trial
      start_search(4'd8, 4'd8, 1'b0, 1, 1'b1);
      wait_drain();
      @(negedge clk);
      chk("busy_low_after_8", int'(busy), 0);

      // target 5 with a start during trial 2, then back-to-back start on done
      start_search(4'd5, 4'd5, 1'b0, 4, 1'b1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         bit seen = 1'b0;
         exp_t e;
         for (int i = 0; i < 10 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
         end
         chk("done_seen_5", int'(seen), 1);
         tgt   = 4'd13;
         start = 1'b1;
         e.res = 4'd13; e.err = 1'b0; e.start_cyc = cyc + 1; e.lat = 4;
         sb.push_back(e);
         @(negedge clk);
         start = 1'b0;
         chk("busy_back_to_back", int'(busy), 1);
      end
      wait_drain();

      // reset mid-search (trial 3), then a fresh search
      start_search(4'd9, 4'd0, 1'b0, 0, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("reset_mid_search", int'({guess, result, done, busy, flag_err}), 0);
      repeat (3) @(negedge clk);
      chk("reset_held_no_done", int'({done, busy}), 0);
      rst = 1'b0;
      start_search(4'd6, 4'd6, 1'b0, 3, 1'b1);
      wait_drain();

      // zero flags at trial 2: kept bit -> 8,12,14,13 -> result 12, sticky error
      start_search(4'd10, 4'd12, 1'b1, 4, 1'b1);
      @(negedge clk);
      ovr_en = 1'b1; ovr = 3'b000;
      @(negedge clk);
      ovr_en = 1'b0;
      chk("flag_err_set", int'(flag_err), 1);
      wait_drain();
      repeat (3) @(negedge clk);
      chk("flag_err_sticky", int'(flag_err), 1);

      // equal + b_greater at trial 1: equal wins, error flagged
      @(negedge clk);
      ovr_en = 1'b1; ovr = 3'b101;
      start_search(4'd3, 4'd8, 1'b1, 1, 1'b1);
      @(negedge clk);
      ovr_en = 1'b0;
      wait_drain();

      // accepted start clears the sticky error; 8,4,6,7
      start_search(4'd7, 4'd7, 1'b0, 4, 1'b1);
      chk("flag_err_cleared", int'(flag_err), 0);
      wait_drain();

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global guard so the run always terminates.
   initial begin
      #20000;
      $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
